block_loader: RTL
=================

Name: block_loader

Overview:
- Upstream feeder for the block memory's loader write port.
- Accepts a load command (base address), then a word-serial stream of BLOCKSIZE signed words from the host/DMA side, and assembles them in a local block buffer.
- Once the buffer is full, issues a single one-cycle block write (aligned address, valid, full block of data) to the block memory.
- Provides ready/valid handshakes upstream, abort, and done/status reporting to the controller.

Parameters:
- BITWIDTH, 8, width of data words and of addresses.
- MESHUNITS, 2, mesh dimension; must match the block memory.
- TILEUNITS, 2, tile dimension; must match the block memory.
- BLOCKSIZE, derived = MESHUNITS*MESHUNITS*TILEUNITS*TILEUNITS, words per block; must be a power of two.

Ports:
- clock  input  1  sole clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  load command present.
- cmd_ready  output  1  loader can accept a command (high only in IDLE).
- cmd_addr  input  BITWIDTH  block base address.
- in_valid  input  1  stream word present.
- in_ready  output  1  loader accepts a word (high only in FILL).
- in_data  input  BITWIDTH  signed stream word.
- abort  input  1  cancel the current load.
- loader_write_addr  output  BITWIDTH  aligned block address to memory.
- loader_write_valid  output  1  one-cycle block write strobe.
- loader_write_data  output  BLOCKSIZE x BITWIDTH (unpacked array)  block contents; index i = i-th accepted word.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse in the cycle after the write strobe.
- misaligned  output  1  sticky; last accepted cmd_addr had nonzero low log2(BLOCKSIZE) bits.
- blocks_loaded  output  BITWIDTH  count of completed block writes; wraps modulo 2^BITWIDTH.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; word counter=0; buffer all 0.
  - loader_write_addr=0, loader_write_valid=0, done=0, misaligned=0, blocks_loaded=0.
  - Takes effect immediately even mid-FILL/WRITE; no write is issued.
- States: IDLE, FILL, WRITE, DONE.
- IDLE:
  - cmd_ready=1, in_ready=0.
  - On cmd_valid: latch addr_reg = cmd_addr with low log2(BLOCKSIZE) bits cleared; set misaligned = (those bits != 0); count=0; go to FILL.
  - abort in IDLE has no effect.
- FILL:
  - in_ready=1, cmd_ready=0.
  - On in_valid, buffer[count] <= in_data and count++. Gaps (in_valid=0) stall without penalty.
  - The word that makes count reach BLOCKSIZE (i.e. accepted at count=BLOCKSIZE-1) moves to WRITE.
  - abort=1 (checked before acceptance): go to IDLE, drop the word presented that cycle, leave buffer contents unspecified-but-stable, no write, no done, blocks_loaded unchanged.
- WRITE (exactly 1 cycle):
  - loader_write_valid=1, loader_write_addr=addr_reg, loader_write_data=buffer.
  - in_ready=0; abort ignored; go to DONE.
- DONE (1 cycle):
  - done=1; blocks_loaded++ (wraps); go to IDLE.
- Output stability:
  - loader_write_addr and loader_write_data are register outputs that hold their values outside WRITE.
  - loader_write_valid is 0 outside WRITE.
- Throughput and latency:
  - Command-to-strobe latency with no stream gaps = BLOCKSIZE+1 cycles after the command cycle.
  - Next command is accepted no earlier than 2 cycles after the strobe.
- Address arithmetic: BITWIDTH-bit unsigned; alignment is a pure mask, with no overflow path.
- Data is passed through unmodified (signed two's complement, no extension).

Test Plan:
- Defaults (BLOCKSIZE=16):
  - Stimulus: cmd_addr=0x20, then stream 1..16 back-to-back.
  - Required: loader_write_valid high for exactly one cycle, 17 cycles after the command cycle.
  - Required: addr=0x20, data[i]=i+1, done the next cycle, blocks_loaded=1, misaligned=0.
- Misaligned command:
  - Stimulus: cmd_addr=0x27, stream -1 x16 with in_valid toggling every other cycle.
  - Required: write to addr 0x20, all data=0xFF, misaligned=1, strobe after 16 accepted words only.
- Abort:
  - Stimulus: abort asserted after 5 words; then a new cmd 0x40 with stream 100..115.
  - Required: no strobe for the first load; second load writes addr 0x40 with data[0]=100, data[15]=115; blocks_loaded increments by exactly 1.
- Asynchronous reset:
  - Stimulus: reset asserted mid-FILL (word 9), between clock edges.
  - Required: all outputs at reset values immediately; no strobe after release; cmd_ready=1 on the first cycle after release.
- Handshake gating:
  - Stimulus: cmd_valid held high in FILL; in_valid held high in IDLE/WRITE/DONE.
  - Required: cmd_ready=0 and in_ready=0 respectively; no words or commands consumed.
- Counter wrap:
  - Stimulus: 256 consecutive loads.
  - Required: blocks_loaded returns to 0.

Source files
------------

// File: rtl/block_loader.sv
// block_loader: collects a word-serial stream into a local block buffer and
// issues a single one-cycle block write to the block memory once it is full.
module block_loader #(
    parameter  int BITWIDTH  = 8,
    parameter  int MESHUNITS = 2,
    parameter  int TILEUNITS = 2,
    localparam int BLOCKSIZE = MESHUNITS * MESHUNITS * TILEUNITS * TILEUNITS
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [BITWIDTH-1:0] cmd_addr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITWIDTH-1:0] in_data,
    input  logic                abort,
    output logic [BITWIDTH-1:0] loader_write_addr,
    output logic                loader_write_valid,
    output logic [BITWIDTH-1:0] loader_write_data [BLOCKSIZE],
    output logic                busy,
    output logic                done,
    output logic                misaligned,
    output logic [BITWIDTH-1:0] blocks_loaded
);
    localparam int CW = $clog2(BLOCKSIZE);
    localparam logic [BITWIDTH-1:0] MASK = BITWIDTH'(BLOCKSIZE - 1);
    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [BITWIDTH-1:0] r_addr;
    logic [BITWIDTH-1:0] r_buf [BLOCKSIZE];
    assign cmd_ready = r_state == IDLE;
    assign in_ready  = r_state == FILL;
    assign busy      = r_state != IDLE;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state            <= IDLE;
            r_cnt              <= '0;
            r_addr             <= '0;
            r_buf              <= '{default: '0};
            loader_write_addr  <= '0;
            loader_write_valid <= 1'b0;
            loader_write_data  <= '{default: '0};
            done               <= 1'b0;
            misaligned         <= 1'b0;
            blocks_loaded      <= '0;
        end else begin
            loader_write_valid <= 1'b0;
            done               <= 1'b0;
            case (r_state)
                IDLE: if (cmd_valid) begin
                    r_addr     <= cmd_addr & ~MASK;
                    misaligned <= |(cmd_addr & MASK);
                    r_cnt      <= '0;
                    r_state    <= FILL;
                end
                FILL: if (abort) begin
                    r_state <= IDLE;
                end else if (in_valid) begin
                    r_buf[r_cnt] <= in_data;
                    r_cnt        <= r_cnt + CW'(1);
                    // The final word bypasses the buffer so the block is complete in WRITE
                    if (r_cnt == CW'(BLOCKSIZE - 1)) begin
                        for (int i = 0; i < BLOCKSIZE; i++)
                            loader_write_data[i] <= (i == BLOCKSIZE - 1) ? in_data : r_buf[i];
                        loader_write_addr  <= r_addr;
                        loader_write_valid <= 1'b1;
                        r_state            <= WRITE;
                    end
                end
                WRITE: begin
                    done          <= 1'b1;
                    blocks_loaded <= blocks_loaded + BITWIDTH'(1);
                    r_state       <= DONE;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
